// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port ram with 1-cycle registered read.
// Optional high-water mark register enabled by defining RAM_FIFO_HWM_EN.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 5,
  parameter int A_MAX   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  output logic [A_WIDTH:0]   count,
  output logic               full,
  output logic               empty,
  output logic [A_WIDTH:0]   hwm
);

  localparam logic [A_WIDTH:0] C_MAX = (A_WIDTH+1)'(A_MAX);

  logic [A_WIDTH-1:0] r_wr_ptr;
  logic [A_WIDTH-1:0] r_rd_ptr;
  logic [A_WIDTH-1:0] r_last_addr;
  logic [A_WIDTH:0]   r_count;
  logic [A_WIDTH:0]   r_unread;
  logic               r_out_valid;

  logic               w_full;
  logic               w_wr;
  logic               w_pop;
  logic               w_rd;
  logic [A_WIDTH:0]   w_count_next;
  logic [A_WIDTH:0]   w_unread_next;

  // in_ready depends on registered occupancy only, so a full FIFO refuses a word even during a pop.
  assign w_full   = (r_count == C_MAX);
  assign in_ready = ~w_full;
  assign w_wr     = in_valid & ~w_full;
  assign w_pop    = r_out_valid & out_ready;
  assign w_rd     = (r_unread != '0) & (~r_out_valid | out_ready);

  assign w_count_next  = r_count + (A_WIDTH+1)'(w_wr) - (A_WIDTH+1)'(w_pop);
  assign w_unread_next = r_unread + (A_WIDTH+1)'(w_wr) - (A_WIDTH+1)'(w_rd);

  // Writes are suppressed while reset is asserted so the ram is never touched during reset.
  assign ram_write_enable  = w_wr & rst_n;
  assign ram_address_write = r_wr_ptr;
  assign ram_data_write    = in_data;
  // When idle the ram keeps re-reading the presented word, holding data_read stable.
  assign ram_address_read  = w_rd ? r_rd_ptr : r_last_addr;

  assign out_data  = ram_data_read;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = (r_count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_addr <= '0;
      r_count     <= '0;
      r_unread    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_unread <= w_unread_next;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + A_WIDTH'(1);
      end
      if (w_rd) begin
        r_last_addr <= r_rd_ptr;
        r_rd_ptr    <= r_rd_ptr + A_WIDTH'(1);
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef RAM_FIFO_HWM_EN
  logic [A_WIDTH:0] r_hwm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (w_count_next > r_hwm) begin
      r_hwm <= w_count_next;
    end
  end

  assign hwm = r_hwm;
`else
  assign hwm = '0;
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of the dual-port `ram`. It owns the ram write and read ports.
- Converts a valid/ready input byte stream into ram writes.
- Presents a first-word-fall-through valid/ready output stream built from the ram's registered `data_read`.
- Integration ties the ram's `clk_write` and `clk_read` to `clk`.

Parameters:
- `D_WIDTH`, 8: data width; must match the ram's `D_WIDTH`.
- `A_WIDTH`, 5: address width; must match the ram's `A_WIDTH`.
- `A_MAX`, 32: FIFO depth; must equal 2^`A_WIDTH`.

Ports:
- `clk`  in  1: single clock for all logic; also drives the ram's `clk_write` and `clk_read`.
- `rst_n`  in  1: synchronous reset, active-low.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: controller accepts the input word.
- `in_data`  in  `D_WIDTH`: input word.
- `out_valid`  out  1: output word present.
- `out_ready`  in  1: consumer accepts the output word.
- `out_data`  out  `D_WIDTH`: output word; wired directly to `ram_data_read`.
- `ram_address_write`  out  `A_WIDTH`: to ram `address_write`.
- `ram_data_write`  out  `D_WIDTH`: to ram `data_write`.
- `ram_write_enable`  out  1: to ram `write_enable`.
- `ram_address_read`  out  `A_WIDTH`: to ram `address_read`.
- `ram_data_read`  in  `D_WIDTH`: from ram `data_read`; registered in the ram on `clk`.
- `count`  out  `A_WIDTH`+1: occupancy, including the word currently presented on the output.
- `full`  out  1: `count` == `A_MAX`.
- `empty`  out  1: `count` == 0.
- `hwm`  out  `A_WIDTH`+1: high-water mark (see Optional Feature).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low, sampled on posedge `clk`.
- Reset values: `wr_ptr`, `rd_ptr`, `last_addr`, `count`, `unread` all 0; `out_valid` 0; `hwm` 0. Consequently `in_ready`=1, `full`=0, `empty`=1, `ram_write_enable`=0.
- Reset mid-operation: all contents discarded. The ram array is not cleared, but it is unreachable because the pointers reset.

Write side:
- `in_ready` = !`full`. It is registered-state-derived only and has no combinational path from `out_ready`. A full FIFO does not accept a word even if a pop occurs in the same cycle.
- Write handshake `wr` = `in_valid` & `in_ready`.
- `ram_write_enable` = `wr`; `ram_address_write` = `wr_ptr`; `ram_data_write` = `in_data`.
- `wr_ptr` increments on `wr` and wraps from `A_MAX`-1 to 0 (natural `A_WIDTH`-bit wrap).

Read side (first-word fall-through over a ram with 1-cycle registered read):
- `unread` = words written to ram but not yet fetched.
- Fetch condition `rd` = (`unread` != 0) & (!`out_valid` | `out_ready`).
- `ram_address_read` = `rd` ? `rd_ptr` : `last_addr`. When idle the ram re-reads the held location, so `data_read` stays stable.
- On `rd`: `last_addr` <= `rd_ptr`; `rd_ptr` increments with wrap; `out_valid` <= 1.
- On !`rd` & `out_valid` & `out_ready`: `out_valid` <= 0.
- The held location is counted in `count`, so the writer can never overwrite it. A fetch never targets the address being written in the same cycle, so there is no ram read-during-write hazard.

Counters:
- `count` next = `count` + `wr` - (`out_valid` & `out_ready`).
- `unread` next = `unread` + `wr` - `rd`.
- Simultaneous push and pop leaves `count` unchanged.

Latency:
- A word written at edge N is fetched at edge N+1 when the output is free, so `out_valid` is seen after N+1. Input-to-output latency is 2 cycles.
- Back-to-back pops with `out_ready` held high sustain 1 word/cycle while `unread` > 0.

Boundary conditions:
- Empty with `out_ready`=1: no fetch; `out_valid` stays 0. `out_data` is don't-care when `out_valid`=0.
- Full (`count`=32): `in_ready`=0 and the write is ignored even with `in_valid`=1.
- Pointer wrap-around is transparent; the data order is preserved.
- `out_valid`=1 with `out_ready`=0: `out_data` stays stable indefinitely.

Optional Feature:
- Macro `RAM_FIFO_HWM_EN`.
- Defined: `hwm` <= `count`_next whenever `count`_next > `hwm`. It never decreases and is cleared only by reset.
- Not defined: `hwm` is tied to 0 and no register is synthesized. The port is always present.

Test Plan:
- Reset: hold `rst_n`=0 for 2 edges with `in_valid`=1 -> `in_ready`=1, `out_valid`=0, `count`=0, `empty`=1, `ram_write_enable` low during reset.
- Single word: push 8'hC5 at edge N, `out_ready`=0 -> `out_valid`=1 after N+1, `out_data`=C5, `count`=1. It stays C5 for 10 cycles, then pops with `out_ready`=1 -> `empty`=1.
- Fill and overflow: push 0x00..0x1F, then hold `in_valid`=1 with 0xAA -> `full`=1, `count`=32, `in_ready`=0. Draining yields exactly 0x00..0x1F, with no 0xAA.
- Wrap and throughput: push 40 incrementing words with `out_ready`=1 continuously -> output identical in order, 1 word/cycle after the 2-cycle fill. `count` never exceeds 2; pointers wrap past 31.
- Simultaneous push/pop: at `count`=5, push and pop on the same edge for 8 cycles -> `count` stays 5 and order is preserved. Then a mid-stream reset -> `count`=0 and `out_valid`=0 on the next cycle.
- With `RAM_FIFO_HWM_EN`: fill to 20, drain to 0, fill to 7 -> `hwm`=20. Without the macro -> `hwm`=0 throughout.
